// File: rtl/scalar_rf_wb_scheduler.sv
// Scoreboard and single write-port scheduler for the scalar register file.
// Stalls issue on RAW/WAW hazards and round-robins ALU/LSU writebacks onto the file's write port.
module scalar_rf_wb_scheduler #(
  parameter int DATA_W = 36,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_issue_valid,
  input  logic [AW-1:0]     i_issue_rs1,
  input  logic [AW-1:0]     i_issue_rs2,
  input  logic              i_issue_use_rs1,
  input  logic              i_issue_use_rs2,
  input  logic              i_issue_wr,
  input  logic [AW-1:0]     i_issue_rd,
  output logic              o_issue_stall,
  input  logic              i_alu_wb_valid,
  input  logic [AW-1:0]     i_alu_wb_rd,
  input  logic [DATA_W-1:0] i_alu_wb_data,
  output logic              o_alu_wb_ready,
  input  logic              i_lsu_wb_valid,
  input  logic [AW-1:0]     i_lsu_wb_rd,
  input  logic [DATA_W-1:0] i_lsu_wb_data,
  output logic              o_lsu_wb_ready,
  output logic              o_rf_we,
  output logic [AW-1:0]     o_rf_waddr,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic              o_idle,
  output logic              o_wb_err
);

  logic [NREG-1:0]   r_busy;
  logic              r_rr_last;
  logic              r_rf_we;
  logic [AW-1:0]     r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_wb_err;

  logic [NREG-1:0]   w_busy_next;
  logic              w_hazard;
  logic              w_issue_fire;
  logic              w_alu_grant;
  logic              w_lsu_grant;
  logic              w_grant;
  logic [AW-1:0]     w_grant_rd;
  logic [DATA_W-1:0] w_grant_data;

  // Hazard check sees only the current scoreboard; a same-cycle grant does not un-stall.
  assign w_hazard = (i_issue_use_rs1 & r_busy[i_issue_rs1])
                  | (i_issue_use_rs2 & r_busy[i_issue_rs2])
                  | (i_issue_wr      & r_busy[i_issue_rd]);

  assign o_issue_stall = i_issue_valid & ~i_rst & w_hazard;
  assign w_issue_fire  = i_issue_valid & ~w_hazard & i_issue_wr;

  // r_rr_last = 1 means the LSU won last, so the ALU takes the next tie.
  assign w_alu_grant  = ~i_rst & i_alu_wb_valid & (~i_lsu_wb_valid | r_rr_last);
  assign w_lsu_grant  = ~i_rst & i_lsu_wb_valid & (~i_alu_wb_valid | ~r_rr_last);
  assign w_grant      = w_alu_grant | w_lsu_grant;
  assign w_grant_rd   = w_lsu_grant ? i_lsu_wb_rd   : i_alu_wb_rd;
  assign w_grant_data = w_lsu_grant ? i_lsu_wb_data : i_alu_wb_data;

  assign o_alu_wb_ready = w_alu_grant;
  assign o_lsu_wb_ready = w_lsu_grant;

  // NOTE: default assignment first so no path leaves w_busy_next unassigned (no latch).
  always_comb begin
    w_busy_next = r_busy;
    if (w_grant)      w_busy_next[w_grant_rd] = 1'b0;
    // Set is applied after clear so it wins on the same register.
    if (w_issue_fire) w_busy_next[i_issue_rd] = 1'b1;
  end

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy     <= '0;
      r_rr_last  <= 1'b1;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_wb_err   <= 1'b0;
    end else begin
      r_busy  <= w_busy_next;
      r_rf_we <= w_grant;
      if (w_grant) begin
        r_rf_waddr <= w_grant_rd;
        r_rf_wdata <= w_grant_data;
        r_rr_last  <= w_lsu_grant;
        if (!r_busy[w_grant_rd]) r_wb_err <= 1'b1;
      end
    end
  end

  assign o_rf_we    = r_rf_we;
  assign o_rf_waddr = r_rf_waddr;
  assign o_rf_wdata = r_rf_wdata;
  assign o_wb_err   = r_wb_err;
  assign o_idle     = (r_busy == '0) & ~r_rf_we;

endmodule

// File: doc/scalar_rf_wb_scheduler.md
# scalar_rf_wb_scheduler

Scoreboard and write-port scheduler for the 32-entry, 36-bit scalar register file. It tracks which registers have writes outstanding and stalls issue on RAW/WAW hazards. It arbitrates the register file's single write port between the ALU and the load/store unit writeback paths. It sits between the decode/issue stage and the scalar register file, and drives the file's `we`, `write_addr` and `write_data`.

## Interface
- `DATA_W`, 36, writeback data width.
- `NREG`, 32, number of scalar registers. Register index width is log2(NREG) = 5.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `issue_valid` input 1: decode presents an instruction.
- `issue_rs1`, `issue_rs2` input 5: source registers.
- `issue_use_rs1`, `issue_use_rs2` input 1: the source is actually read.
- `issue_wr` input 1: the instruction writes `issue_rd`.
- `issue_rd` input 5: destination register.
- `issue_stall` output 1: combinational; the instruction must not issue this cycle.
- `alu_wb_valid`, `lsu_wb_valid` input 1: writeback request per source.
- `alu_wb_rd`, `lsu_wb_rd` input 5: writeback destination.
- `alu_wb_data`, `lsu_wb_data` input DATA_W: writeback value.
- `alu_wb_ready`, `lsu_wb_ready` output 1: combinational grant.
- `rf_we` output 1, `rf_waddr` output 5, `rf_wdata` output DATA_W: registered register file write port.
- `idle` output 1: no busy bits set and `rf_we` low.
- `wb_err` output 1: sticky; set when a writeback targets a register that is not busy.

## Operation
- State:
  - `busy[NREG-1:0]` scoreboard.
  - `rr_last`: 0 means the ALU was granted last, 1 means the LSU was.
  - Write-port output registers.
  - `wb_err`.
- `issue_stall` = `issue_valid` & (`issue_use_rs1` & `busy[rs1]` | `issue_use_rs2` & `busy[rs2]` | `issue_wr` & `busy[rd]`).
  - Stall uses the current-cycle `busy` only. A writeback granted in the same cycle does not un-stall.
- Issue fires when `issue_valid` & !`issue_stall`. If `issue_wr` is also set, `busy[rd]` is set at the clock edge.
- Arbitration:
  - Only one valid source: it is granted.
  - Both valid: the source not equal to `rr_last` is granted.
  - `rr_last` updates only on a grant.
  - A source holds `valid`, `rd` and `data` stable until it sees `ready`.
- On a grant:
  - `rf_we` <= 1, `rf_waddr` <= granted rd, `rf_wdata` <= granted data.
  - `busy[rd]` <= 0.
  - With no grant, `rf_we` <= 0. `rf_waddr` and `rf_wdata` hold their values.
- Same-edge set and clear on the same register: the set wins. This case is only reachable from an error path, because WAW stalls prevent it.
- Granted writeback with `busy[rd]` = 0: `wb_err` <= 1. The write still proceeds.
- `wb_err` clears only on `rst`.
- `idle` = (`busy` == 0) & !`rf_we`.

## Timing
- Reset: `busy` = 0, `rr_last` = 1 (ALU wins the first tie), `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0, `wb_err` = 0.
  - During reset both readies are 0 and `issue_stall` is 0.
  - Requests present during reset are not granted.
- Writeback latency: grant in cycle N, `rf_we` high in N+1, register file updated at the end of N+1.
- `busy` clears at the end of N. A consumer issuing in N+1 reads the file in N+1, and the file's same-cycle write forwarding supplies the value. No extra bubble.
- Issue-to-busy: the bit is visible from the cycle after issue, so back-to-back dependent issues stall correctly.
- Throughput: one writeback per cycle. Under continuous contention each source gets every other cycle.
- Reset asserted mid-operation discards all pending busy bits and any in-flight `rf_we` on the next edge.

## Test plan
- Reset, then ALU writeback rd=5 with busy[5] pre-set by an issue:
  - `alu_wb_ready`=1 the same cycle.
  - Next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=36'h9_0000_0001.
  - busy[5]=0 and `wb_err`=0.
- Issue rd=7 at cycle 0, then an instruction with rs1=7 from cycle 1:
  - `issue_stall`=1 until the writeback to 7 is granted.
  - Stall drops the cycle after the grant, coincident with `rf_we`=1, `rf_waddr`=7.
- Both sources valid for 4 cycles (rd=1..4, pre-busied):
  - Grant order ALU, LSU, ALU, LSU.
  - `rf_we` high 4 consecutive cycles.
  - `idle`=1 after the last write drains.
- WAW: busy[3] set, issue with `issue_wr`=1, rd=3, `issue_use_rs*`=0:
  - `issue_stall`=1.
  - With `issue_wr`=0 and both uses 0: `issue_stall`=0.
- Writeback rd=9 with busy[9]=0:
  - `wb_err`=1 from the next cycle and stays set.
  - `rf_we`=1, `rf_waddr`=9.
  - Cleared only by `rst`.
- Assert `rst` with busy[2], busy[10] set and a grant in progress:
  - Next cycle `busy`=0, `rf_we`=0, `idle`=1.
  - Both readies stay 0 while `rst` is high.
